// File: rtl/mux16_rr_sched_pkg.sv
// Shared types and helpers for the 16-requester round-robin mux scheduler.
// Optional feature macro: MUX16_SCHED_PRIO0_EN (requester 0 fixed highest priority).
package mux16_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan upward from ptr (wrapping 15->0); the lowest offset from ptr wins.
    // Walking the offsets from highest to lowest lets the closest hit overwrite.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Request/data/grant bundle between the requesters and the mux scheduler.
interface mux16_rr_sched_if;
    import mux16_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data;
    logic [N_REQ-1:0] grant;
    logic [SEL_W-1:0] select;
    logic             valid;
    logic             y;

    // Requester side: drives requests and data, observes grant and mux output.
    modport master (
        output req, data,
        input  grant, select, valid, y
    );

    // Scheduler side.
    modport slave (
        input  req, data,
        output grant, select, valid, y
    );

endinterface

// File: rtl/mux16_rr_sched_mux.sv
// Existing 16:1 single-bit multiplexer datapath.
module mux_16x1
    import mux16_sched_pkg::*;
(
    input  logic [N_REQ-1:0] data,
    input  logic [SEL_W-1:0] select,
    output logic             y
);

    assign y = data[select];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving the select of a shared 16:1 bit mux.
// Grants are held until the owner drops its request or MAX_HOLD cycles pass.
// Optional macro MUX16_SCHED_PRIO0_EN: requester 0 wins every arbitration point.
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    mux16_rr_sched_if.slave   bus
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic             valid_q, valid_d;
    logic             raw_y;

    pick_t            pick;
    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] next_ptr;
    logic             rel;

    // Arbitration, hold counting and release handling.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        grant_d  = grant_q;
        select_d = select_q;
        valid_d  = valid_q;
        pick     = '0;
        masked   = bus.req;
        next_ptr = select_q + SEL_W'(1);
        rel      = 1'b0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
`ifdef MUX16_SCHED_PRIO0_EN
                if (bus.req[0]) pick = {1'b1, SEL_W'(0)};
`endif
                if (pick.found) begin
                    grant_d  = N_REQ'(1) << pick.idx;
                    select_d = pick.idx;
                    valid_d  = 1'b1;
                    hold_d   = 8'd1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                rel = !bus.req[select_q] || (hold_q == HOLD_LIM);
                if (rel) begin
                    // The releasing owner is masked so a forced release
                    // hands the mux to any other waiting requester first.
                    ptr_d  = next_ptr;
                    masked = bus.req & ~(N_REQ'(1) << select_q);
                    pick   = rr_pick(masked, next_ptr);
`ifdef MUX16_SCHED_PRIO0_EN
                    if (bus.req[0]) pick = {1'b1, SEL_W'(0)};
`endif
                    if (pick.found) begin
                        grant_d  = N_REQ'(1) << pick.idx;
                        select_d = pick.idx;
                        hold_d   = 8'd1;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        hold_d  = 8'd0;
                        state_d = IDLE;
                    end
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
            select_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            valid_q  <= valid_d;
        end
    end

    mux_16x1 u_mux (
        .data   (bus.data),
        .select (select_q),
        .y      (raw_y)
    );

    assign bus.grant  = grant_q;
    assign bus.select = select_q;
    assign bus.valid  = valid_q;
    assign bus.y      = valid_q & raw_y;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: vector table, hand sequences for
// rotation / hold limit / reset mid-grant, then randomized traffic against
// an integer-level reference model.
module tb_mux16_rr_sched;

    localparam int MAXH = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mux16_rr_sched_if bus();

    mux16_rr_sched #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: who owns the mux, for how long, and where the scan starts.
    bit m_busy;
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_cnt;

    function automatic int pick_idx(input logic [15:0] r, input int p);
        for (int off = 0; off < 16; off++) begin
            if (r[(p + off) % 16]) return (p + off) % 16;
        end
        return -1;
    endfunction

    function automatic int arb(input logic [15:0] r, input logic r0, input int p);
`ifdef MUX16_SCHED_PRIO0_EN
        if (r0) return 0;
`else
        if (r0 && 1'b0) return 0;
`endif
        return pick_idx(r, p);
    endfunction

    task automatic model_edge(input logic rn, input logic [15:0] r);
        int w;
        logic [15:0] cand;
        if (!rn) begin
            m_busy = 0; m_owner = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            w = arb(r, r[0], m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_sel = w; m_cnt = 1;
            end
        end else if (!r[m_owner] || m_cnt == MAXH) begin
            m_ptr = (m_owner + 1) % 16;
            cand = r;
            cand[m_owner] = 1'b0;
            w = arb(cand, r[0], m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_cnt = 1;
            end else begin
                m_busy = 0; m_cnt = 0;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [21:0] model_out(input logic [15:0] d);
        logic [15:0] g;
        logic yy;
        g  = m_busy ? (16'd1 << m_owner) : 16'd0;
        yy = m_busy ? d[m_owner] : 1'b0;
        return {g, 4'(m_sel), m_busy, yy};
    endfunction

    function automatic logic [21:0] dut_out();
        return {bus.grant, bus.select, bus.valid, bus.y};
    endfunction

    // Called at a falling edge: apply inputs, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic rn, input logic [15:0] r, input logic [15:0] d);
        rst_n    = rn;
        bus.req  = r;
        bus.data = d;
        model_edge(rn, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%b y=%b, want grant=%h sel=%0d valid=%b y=%b",
                     name, act[21:6], act[5:2], act[1], act[0], exp[21:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    typedef struct {
        logic        rn;
        logic [15:0] req;
        logic [15:0] data;
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic        y;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [15:0] r, d;
        total = 0;
        bad   = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.data = '0;

        tbl[0]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0010, 16'h0010, 16'h0010, 4'd4, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 16'h0000, 16'h0010, 16'h0000, 4'd4, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0006, 16'h0002, 16'h0002, 4'd1, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 16'h0006, 16'h0002, 16'h0002, 4'd1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 16'h0006, 16'h0002, 16'h0002, 4'd1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 16'h0004, 16'h0002, 16'h0004, 4'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'h0004, 16'h0004, 16'h0004, 4'd2, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 16'h0000, 16'h0004, 16'h0000, 4'd2, 1'b0, 1'b0};

        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rn, tbl[i].req, tbl[i].data);
            check($sformatf("vec%0d", i), dut_out(),
                  {tbl[i].grant, tbl[i].sel, tbl[i].valid, tbl[i].y});
        end

        // Rotation between requesters 0 and 15 under the hold limit, no bubbles.
        step(1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 34; k++) begin
            int own;
            step(1'b1, 16'h8001, 16'h8000);
            own = ((k / MAXH) % 2 == 0) ? 0 : 15;
            check($sformatf("rotate%0d", k), dut_out(),
                  {16'd1 << own, 4'(own), 1'b1, (own == 15)});
        end

        // Lone requester held past the limit: one idle cycle every MAXH+1.
        step(1'b0, 16'h0000, 16'h0000);
        for (int k = 0; k < 27; k++) begin
            logic on;
            step(1'b1, 16'h0001, 16'h0001);
            on = ((k % (MAXH + 1)) != MAXH);
            check($sformatf("starve%0d", k), dut_out(),
                  {on ? 16'h0001 : 16'h0000, 4'd0, on, on});
        end

        // Reset while requester 9 owns the mux, then regrant one edge after release.
        step(1'b0, 16'h0000, 16'h0000);
        step(1'b1, 16'h0200, 16'h0200);
        step(1'b1, 16'h0200, 16'h0200);
        check("midgrant_pre", dut_out(), {16'h0200, 4'd9, 1'b1, 1'b1});
        step(1'b0, 16'h0200, 16'h0200);
        check("midgrant_rst", dut_out(), {16'h0000, 4'd0, 1'b0, 1'b0});
        step(1'b1, 16'h0200, 16'h0200);
        check("midgrant_regrant", dut_out(), {16'h0200, 4'd9, 1'b1, 1'b1});

        // Randomized traffic against the reference model.
        r = 16'h0000;
        for (int k = 0; k < 400; k++) begin
            logic rn;
            if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            d  = 16'($urandom);
            rn = ($urandom_range(0, 59) != 0);
            step(rn, r, d);
            check($sformatf("rand%0d", k), dut_out(), model_out(d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
- Round-robin scheduler that shares one 16:1 bit multiplexer between 16 requesters.
- Arbitrates the request vector and holds each grant until the requester releases it or a hold limit expires.
- Drives the mux select and gates the selected data bit.
- Sits directly in front of the existing 16x1 mux datapath, replacing the hand-driven select.

Parameters:
- N_REQ, 16, number of requesters (fixed to 16; matches the mux width).
- SEL_W, 4, select width, log2(N_REQ).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  16  per-requester request; level, held high while the requester wants the mux.
- data  input  16  mux data inputs; bit i belongs to requester i.
- grant  output  16  one-hot registered grant; all zero when idle.
- select  output  4  registered mux select; equals the index of the grant bit.
- valid  output  1  registered; high while any grant is active.
- y  output  1  combinational; data[select] when valid=1, else 0.

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - grant=0, select=0, valid=0, ptr=0, hold_cnt=0, state=IDLE.
  - y=0 after the reset edge.
  - Reset mid-grant drops the grant at that edge, with no release cycle.
- States:
  - IDLE: no grant.
  - BUSY: grant held for requester `select`.
- Arbitration function:
  - Scan req starting at index ptr, upward, wrapping 15->0.
  - The first set bit wins. ptr is the highest-priority index.
- IDLE:
  - If req != 0, then next edge: grant=onehot(winner), select=winner, valid=1, hold_cnt=1, state=BUSY.
  - Latency from req rising to grant is 1 cycle.
- BUSY, release condition: req[select]=0, or hold_cnt==MAX_HOLD.
- BUSY, on release at an edge:
  - ptr <= (select+1) mod 16; the wrap from 15 gives 0.
  - Re-arbitrate in the same edge using the new ptr, masking out the current select.
  - If another requester wins: grant switches to it with no bubble, and hold_cnt=1.
  - If none wins: go to IDLE with grant=0, valid=0; select keeps its last value.
- BUSY, no release: hold_cnt increments, saturating at MAX_HOLD.
- Forced release with req[select] still high:
  - The requester loses the grant.
  - It may win again only after every other pending requester has been served, or immediately if no other req is set. In that case it re-grants after one IDLE cycle.
- Requests rising while BUSY are only seen at the next arbitration point; there is no preemption.
- grant, select and valid change only on clk edges. y follows data combinationally.
- Invariant: popcount(grant) <= 1, and valid == |grant.

Optional Feature:
- Macro: MUX16_SCHED_PRIO0_EN.
- Defined:
  - Requester 0 is fixed highest priority at every arbitration point (IDLE grant or release), regardless of ptr.
  - Forced release still applies to requester 0. If req[0] is still high, it regrants requester 0 immediately, with no IDLE cycle.
  - ptr updates as normal for all other winners.
- Undefined: pure round-robin as specified above.

Decomposition:
- Package mux16_sched_pkg holds:
  - N_REQ, SEL_W.
  - The state enum {IDLE, BUSY}.
  - A function rr_pick(req, ptr) returning the winner index plus a found flag.
- Natural sub-module: instantiate the existing mux_16x1 (data, select -> raw y).
- Gate its output with valid in this block.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=16'hFFFF -> grant=0, select=0, valid=0, y=0. First grant appears on the 1st edge after rst_n=1, to requester 0.
- Single requester: req=16'h0010, data=16'h0010 -> next edge grant=16'h0010, select=4, valid=1, y=1. Drop req[4] -> next edge grant=0, valid=0, y=0.
- Round-robin rotation with MAX_HOLD=8: req=16'h8001 held constant.
  - Grant order: 0 (8 cycles), 15 (8 cycles), 0, ...
  - Each switch is bubble-free; ptr wraps 15->0.
- Early release: req=16'h0006, requester 1 drops after 3 cycles -> grant moves to requester 2 at the same edge, with hold_cnt restarting.
- Starvation limit: req=16'h0001 held 20 cycles, MAX_HOLD=8 -> grant high 8 cycles, 1 IDLE cycle, regrant. Repeats; valid low exactly 1 cycle in 9.
- Reset mid-grant: rst_n=0 while select=9, valid=1 -> same edge grant=0, valid=0, select=0. After rst_n=1 with req=16'h0200 -> requester 9 regranted 1 cycle later.
